// File: rtl/pattern_sequencer_pkg.sv
// Shared types and helpers for the pattern sequencer.
//   state_t       : playback state machine encoding (IDLE / RUN)
//   MODE_LOOP     : mode input value that repeats the frame
//   MODE_ONESHOT  : mode input value that plays one frame and stops
//   clamp_length  : maps a requested frame length onto 1..max_len
package pattern_sequencer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic MODE_LOOP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  // A length of 0, or anything longer than the pattern storage, plays the
  // full pattern width.
  function automatic int unsigned clamp_length(input int unsigned len,
                                               input int unsigned max_len);
    return ((len == 0) || (len > max_len)) ? max_len : len;
  endfunction

endpackage

// File: rtl/pattern_sequencer_tick_divider.sv
// Programmable tick divider: a TICK_W counter that runs 0..rate-1 while
// enabled and flags the last count of each period.
//   clk   : clock
//   rst   : synchronous reset, active-high
//   load  : capture rate (0 treated as 1) and restart the count at 0
//   rate  : cycles per tick period
//   clear : force the count back to 0 (lower priority than load)
//   en    : let the count advance; also qualifies the tick output
//   tick  : high during the final cycle (count == rate-1) of each period
module pattern_sequencer_tick_divider #(
  parameter int TICK_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [TICK_W-1:0] rate,
  input  logic              clear,
  input  logic              en,
  output logic              tick
);

  logic [TICK_W-1:0] rate_q;
  logic [TICK_W-1:0] count_q;
  logic              at_end;

  assign at_end = (count_q == rate_q - TICK_W'(1));
  assign tick   = en && at_end;

  // NOTE: sequential state is assigned with <= only, so every register in
  // the design samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rate_q  <= '0;
      count_q <= '0;
    end else if (load) begin
      rate_q  <= (rate == '0) ? TICK_W'(1) : rate;
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= at_end ? '0 : count_q + TICK_W'(1);
    end
  end

endmodule

// File: rtl/pattern_sequencer.sv
// Multi-channel pattern sequencer: plays CHANNELS bit patterns in lockstep,
// one bit per programmable tick period, with double-buffered loading.
//   CLK, RST     : clock and synchronous active-high reset
//   load         : write load_pattern into the staging buffer of load_channel
//   load_channel : target channel; values >= CHANNELS are ignored
//   load_pattern : pattern, bit 0 plays first
//   start, stop  : begin playback (from IDLE only) / abort playback
//   mode         : 0 = loop, 1 = one-shot (sampled at start)
//   tick_rate    : cycles per bit, 0 acts as 1 (sampled at start)
//   length       : bits per frame, 0 or too large acts as MESSAGE_WIDTH
//   out          : current bit of each channel's active pattern, 0 when idle
//   busy         : high while playing
//   frame        : one-cycle pulse when bit 0 of a frame is first shown
//   done         : one-cycle pulse when a one-shot frame completes
//   bit_index    : index of the bit currently shown
module pattern_sequencer
  import pattern_sequencer_pkg::*;
#(
  parameter  int CHANNELS      = 2,
  parameter  int MESSAGE_WIDTH = 32,
  parameter  int TICK_W        = 32,
  localparam int CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int IDX_W         = $clog2(MESSAGE_WIDTH),
  localparam int LEN_W         = $clog2(MESSAGE_WIDTH + 1)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     load,
  input  logic [CH_W-1:0]          load_channel,
  input  logic [MESSAGE_WIDTH-1:0] load_pattern,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     mode,
  input  logic [TICK_W-1:0]        tick_rate,
  input  logic [LEN_W-1:0]         length,
  output logic [CHANNELS-1:0]      out,
  output logic                     busy,
  output logic                     frame,
  output logic                     done,
  output logic [IDX_W-1:0]         bit_index
);

  state_t             state_q;
  state_t             next_state;
  logic               mode_q;
  logic [LEN_W-1:0]   len_q;
  logic [IDX_W-1:0]   bit_index_q;
  logic               frame_q;
  logic               done_q;
  logic               tick;
  logic               last_bit;
  logic               start_go;
  logic               frame_end;
  logic               wrap;
  logic               finish;
  logic               copy;
  logic [CHANNELS-1:0] active_bit;

  // stop has priority over start and over every end-of-frame action.
  assign start_go  = (state_q == IDLE) && start && !stop;
  assign last_bit  = (LEN_W'(bit_index_q) == len_q - LEN_W'(1));
  assign frame_end = (state_q == RUN) && tick && last_bit;
  assign wrap      = frame_end && !stop && (mode_q == MODE_LOOP);
  assign finish    = frame_end && !stop && (mode_q == MODE_ONESHOT);
  // Active buffers reload from staging on every start and every loop wrap.
  assign copy      = start_go || wrap;

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= next_state;
  end

  // NOTE: every signal written in an always_comb gets a default on entry so
  // no path through the block leaves it unassigned and infers a latch.
  always_comb begin
    next_state = state_q;
    case (state_q)
      IDLE:    if (start_go) next_state = RUN;
      RUN:     if (stop || finish) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    out  = '0;
    if (state_q == RUN) begin
      busy = 1'b1;
      out  = active_bit;
    end
  end

  assign frame     = frame_q;
  assign done      = done_q;
  assign bit_index = bit_index_q;

  // The counter is held at 0 whenever the next state is IDLE, so a stop or
  // a one-shot finish leaves it cleared for the following start.
  pattern_sequencer_tick_divider #(
    .TICK_W (TICK_W)
  ) u_tick_divider (
    .clk   (CLK),
    .rst   (RST),
    .load  (start_go),
    .rate  (tick_rate),
    .clear (next_state == IDLE),
    .en    (state_q == RUN),
    .tick  (tick)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_q      <= MODE_LOOP;
      len_q       <= '0;
      bit_index_q <= '0;
      frame_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      frame_q <= copy;
      done_q  <= finish;
      if (start_go) begin
        mode_q <= mode;
        len_q  <= LEN_W'(clamp_length(32'(length), 32'(MESSAGE_WIDTH)));
      end
      if ((next_state == IDLE) || copy) begin
        bit_index_q <= '0;
      end else if ((state_q == RUN) && tick) begin
        bit_index_q <= bit_index_q + IDX_W'(1);
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [MESSAGE_WIDTH-1:0] staging_q;
    logic [MESSAGE_WIDTH-1:0] active_q;
    logic                     load_hit;

    assign load_hit = load && (load_channel == CH_W'(c));

    // NOTE: the pattern buffers are ordinary flops, so they are cleared by
    // reset along with the control state; a restart after reset plays zeros.
    always_ff @(posedge CLK) begin
      if (RST) begin
        staging_q <= '0;
        active_q  <= '0;
      end else begin
        if (load_hit) staging_q <= load_pattern;
        // A load coinciding with a copy is forwarded straight to active.
        if (copy) active_q <= load_hit ? load_pattern : staging_q;
      end
    end

    assign active_bit[c] = active_q[bit_index_q];
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Self-checking bench for pattern_sequencer (CHANNELS = 2, MESSAGE_WIDTH = 8).
// Expected per-cycle outputs are queued when stimulus is driven and compared
// at each falling edge; a 3-channel instance covers out-of-range channels.
module tb_pattern_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        load, start, stop, mode;
  logic [0:0]  load_channel;
  logic [7:0]  load_pattern;
  logic [31:0] tick_rate;
  logic [3:0]  length;
  logic [1:0]  out;
  logic        busy, frame, done;
  logic [2:0]  bit_index;

  logic        b_load, b_start;
  logic [1:0]  b_ch;
  logic [7:0]  b_pat;
  logic [2:0]  b_out;
  logic        b_busy, b_frame, b_done;
  logic [2:0]  b_idx;

  always #5 clk = ~clk;

  pattern_sequencer #(.CHANNELS(2), .MESSAGE_WIDTH(8), .TICK_W(32)) dut (
    .CLK(clk), .RST(rst), .load(load), .load_channel(load_channel),
    .load_pattern(load_pattern), .start(start), .stop(stop), .mode(mode),
    .tick_rate(tick_rate), .length(length), .out(out), .busy(busy),
    .frame(frame), .done(done), .bit_index(bit_index)
  );

  pattern_sequencer #(.CHANNELS(3), .MESSAGE_WIDTH(8), .TICK_W(32)) dut3 (
    .CLK(clk), .RST(rst), .load(b_load), .load_channel(b_ch),
    .load_pattern(b_pat), .start(b_start), .stop(stop), .mode(mode),
    .tick_rate(tick_rate), .length(length), .out(b_out), .busy(b_busy),
    .frame(b_frame), .done(b_done), .bit_index(b_idx)
  );

  // {out[1:0], busy, frame, done, bit_index[2:0]}
  typedef struct packed {
    logic [1:0] out;
    logic       busy;
    logic       frame;
    logic       done;
    logic [2:0] idx;
  } exp_t;

  typedef struct {
    logic [31:0] rate;
    logic [3:0]  len;
    int          exp_rate;
    int          exp_len;
  } edge_vec_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  string      phase  = "init";
  logic [7:0] pat0, pat1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: inputs were set at the previous falling edge; outputs are
  // compared at this falling edge against the oldest queued expectation.
  task automatic cycle();
    logic [7:0] got;
    logic [7:0] want;
    @(posedge clk);
    @(negedge clk);
    if (sb.size() > 0) begin
      want = sb.pop_front();
      got  = {out, busy, frame, done, bit_index};
      check(phase, {24'b0, got}, {24'b0, want});
    end
  endtask

  task automatic push_idle(input int n);
    repeat (n) sb.push_back('0);
  endtask

  task automatic push_run(input logic [1:0] o, input logic f, input int i);
    exp_t e;
    e = '{out: o, busy: 1'b1, frame: f, done: 1'b0, idx: 3'(i)};
    sb.push_back(e);
  endtask

  task automatic push_frame(input logic [7:0] p0, input logic [7:0] p1,
                            input int rate, input int len);
    for (int i = 0; i < len; i++)
      for (int r = 0; r < rate; r++)
        push_run({p1[i], p0[i]}, (i == 0) && (r == 0), i);
  endtask

  task automatic push_done();
    exp_t e;
    e = '{out: 2'b00, busy: 1'b0, frame: 1'b0, done: 1'b1, idx: 3'd0};
    sb.push_back(e);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic load_ch(input logic [0:0] ch, input logic [7:0] pat);
    load = 1'b1; load_channel = ch; load_pattern = pat;
    cycle();
    load = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() > 0 && guard < 2000) begin
      cycle();
      guard++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    edge_vec_t vecs[5];
    vecs[0] = '{32'd0, 4'd4,  1, 4};
    vecs[1] = '{32'd1, 4'd9,  1, 8};
    vecs[2] = '{32'd2, 4'd0,  2, 8};
    vecs[3] = '{32'd3, 4'd3,  3, 3};
    vecs[4] = '{32'd1, 4'd15, 1, 8};

    rst = 1'b1; load = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0;
    load_channel = '0; load_pattern = '0; tick_rate = '0; length = '0;
    b_load = 1'b0; b_start = 1'b0; b_ch = '0; b_pat = '0;

    // Reset state.
    phase = "reset";
    cycle();
    push_idle(2);
    cycle();
    cycle();
    check("reset b_out", {29'b0, b_out}, 32'd0);
    check("reset b_busy", {31'b0, b_busy}, 32'd0);
    rst = 1'b0;

    // Out-of-range channel on a 3-channel instance is ignored.
    phase = "chan_ignore";
    b_load = 1'b1; b_ch = 2'd3; b_pat = 8'hFF;
    cycle();
    b_ch = 2'd2; b_pat = 8'h01;
    cycle();
    b_load = 1'b0;
    mode = 1'b1; tick_rate = 32'd1; length = 4'd8;
    b_start = 1'b1;
    cycle();
    b_start = 1'b0;
    check("ign frame", {31'b0, b_frame}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      check("ign out", {29'b0, b_out}, (k == 0) ? 32'd4 : 32'd0);
      check("ign idx", {29'b0, b_idx}, 32'(k));
      cycle();
    end
    check("ign done", {31'b0, b_done}, 32'd1);

    // Basic loop playback: two full frames, then stop.
    phase = "basic";
    pat0 = 8'b1011_0010; pat1 = 8'hFF;
    push_idle(2);
    load_ch(1'b0, pat0);
    load_ch(1'b1, pat1);
    mode = 1'b0; tick_rate = 32'd3; length = 4'd0;
    push_frame(pat0, pat1, 3, 8);
    push_frame(pat0, pat1, 3, 8);
    push_idle(2);
    pulse_start();
    repeat (47) cycle();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    cycle();

    // One-shot with a restart requested in the done cycle.
    phase = "oneshot";
    mode = 1'b1; tick_rate = 32'd2; length = 4'd4;
    push_frame(pat0, pat1, 2, 4);
    push_done();
    push_frame(pat0, pat1, 2, 4);
    push_done();
    push_idle(1);
    pulse_start();
    repeat (7) cycle();
    cycle();
    start = 1'b1;
    cycle();
    start = 1'b0;
    drain();

    // Mid-play load, then a load on the wrap cycle itself.
    phase = "midload";
    mode = 1'b0; tick_rate = 32'd1; length = 4'd8;
    push_frame(pat0, pat1, 1, 8);
    push_frame(8'h0F, pat1, 1, 8);
    push_frame(8'h0F, 8'h55, 1, 8);
    push_idle(1);
    pulse_start();
    for (int k = 1; k < 24; k++) begin
      load = 1'b0;
      if (k == 3) begin
        load = 1'b1; load_channel = 1'b0; load_pattern = 8'h0F;
      end else if (k == 16) begin
        load = 1'b1; load_channel = 1'b1; load_pattern = 8'h55;
      end
      cycle();
    end
    load = 1'b0;
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    pat0 = 8'h0F; pat1 = 8'h55;

    // start+stop together stays idle; stop on final one-shot cycle.
    phase = "collide";
    push_idle(2);
    start = 1'b1; stop = 1'b1;
    cycle();
    start = 1'b0; stop = 1'b0;
    cycle();
    mode = 1'b1; tick_rate = 32'd2; length = 4'd4;
    push_frame(pat0, pat1, 2, 4);
    push_idle(2);
    pulse_start();
    repeat (7) cycle();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    cycle();

    // Edge rates/lengths; settings changed mid-run must not matter.
    phase = "edges";
    for (int v = 0; v < 5; v++) begin
      mode = 1'b1; tick_rate = vecs[v].rate; length = vecs[v].len;
      push_frame(pat0, pat1, vecs[v].exp_rate, vecs[v].exp_len);
      push_done();
      pulse_start();
      tick_rate = 32'd7; length = 4'd2; mode = 1'b0;
      drain();
    end

    // Reset during playback clears everything, including the patterns.
    phase = "midreset";
    mode = 1'b0; tick_rate = 32'd1; length = 4'd8;
    for (int i = 0; i < 3; i++) push_run({pat1[i], pat0[i]}, i == 0, i);
    push_idle(1);
    pulse_start();
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    pat0 = 8'h00; pat1 = 8'h00;
    push_frame(pat0, pat1, 1, 8);
    push_idle(1);
    pulse_start();
    repeat (7) cycle();
    stop = 1'b1;
    cycle();
    stop = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_sequencer.md
# pattern_sequencer

Multi-channel, parametrised successor to the single-LED tick-rate blinker. It plays up to CHANNELS independent bit patterns in lockstep, one bit per programmable tick period, and drives LED or pin outputs on the TinyFPGA BX top level. Unlike the blinker, it has a synchronous reset, runtime tick rate and message length, loop or one-shot mode, start/stop control and double-buffered pattern loading. Patterns can therefore be changed mid-play without glitching the frame in progress.

## Interface
Parameters:
- CHANNELS, 2, number of independent output channels (≥1)
- MESSAGE_WIDTH, 32, maximum pattern length in bits (≥2)
- TICK_W, 32, width of the tick-rate input and internal tick counter
- Derived: CH_W = max(1, $clog2(CHANNELS)); IDX_W = $clog2(MESSAGE_WIDTH); LEN_W = $clog2(MESSAGE_WIDTH+1)

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
  - CLK  in  1  system clock (16 MHz on BX)
  - RST  in  1  synchronous reset, active-high
- Pattern loading:
  - load  in  1  write load_pattern into the staging buffer of load_channel
  - load_channel  in  CH_W  target channel; values ≥ CHANNELS are ignored
  - load_pattern  in  MESSAGE_WIDTH  pattern; bit 0 plays first
- Playback control:
  - start  in  1  begin playback; honoured only in IDLE
  - stop  in  1  abort playback
  - mode  in  1  0 = loop, 1 = one-shot; sampled at start
  - tick_rate  in  TICK_W  cycles per bit; sampled at start; 0 is treated as 1
  - length  in  LEN_W  bits per frame; sampled at start; 0 or >MESSAGE_WIDTH is treated as MESSAGE_WIDTH
- Outputs:
  - out  out  CHANNELS  current bit of each channel's active pattern
  - busy  out  1  high in RUN
  - frame  out  1  one-cycle pulse when bit 0 of a frame is first presented
  - done  out  1  one-cycle pulse on one-shot completion
  - bit_index  out  IDX_W  index of the bit currently presented

## Operation
- Storage:
  - Per channel: a staging register (written by load) and an active register (drives out).
  - A load is also accepted in the same cycle as a staging→active copy, and the copy uses the newly loaded value (bypass).
- State machine, IDLE ↔ RUN:
  - IDLE: out = 0, busy = 0, bit_index = 0, tick counter = 0.
  - IDLE → RUN on start && !stop. Latch mode, tick_rate and length; copy staging→active for all channels; pulse frame.
  - RUN: the tick counter counts 0..rate−1. On count == rate−1 the counter clears, and then:
    - If bit_index < len−1: bit_index increments.
    - Else, at end of frame, in loop mode: bit_index → 0, staging→active copy, frame pulse.
    - Else, at end of frame, in one-shot mode: → IDLE with a done pulse.
  - RUN → IDLE on stop at any cycle; no done pulse; out = 0 next cycle.
- Simultaneous events:
  - stop beats start.
  - stop beats frame end: no done and no frame pulse.
  - start during RUN is ignored.
  - Changes to tick_rate, length or mode during RUN have no effect until the next start.
- out[c] = active[c][bit_index] while busy, else 0.
- RST clears both staging and active buffers, counters and state.

## Timing
- Reset values: out = 0, busy = 0, frame = 0, done = 0, bit_index = 0; all storage 0.
- start sampled at cycle t: at t+1, busy = 1, frame = 1, bit_index = 0, out = bit 0.
- Each bit is presented for exactly rate cycles. With rate = 1, bit_index advances every cycle.
- One frame lasts len × rate cycles.
  - Loop mode: the next frame's bit 0 (and its frame pulse) appears immediately, with no gap cycle.
  - One-shot mode: done = 1 and busy = 0 in the cycle after the last bit's final cycle. start is accepted again that same cycle, so the earliest restart is presented one cycle later.
- stop at t: busy = 0 and out = 0 at t+1.
- load at t: staging is updated at t+1. It reaches out only at the next start or loop wrap.
- All outputs are registered or decoded from registers; there are no combinational paths from inputs to outputs.

## Structure
- Shared package pattern_sequencer_pkg:
  - state enum {IDLE, RUN}
  - MODE_LOOP / MODE_ONESHOT constants
  - function clamping length to MESSAGE_WIDTH
- Natural sub-module: tick_divider. It holds a loadable TICK_W counter with a clear input and emits a one-cycle tick pulse at rate−1. It is reusable by the tone generator.
- Channel storage is a generate loop over CHANNELS; no per-channel sub-module.

## Test plan
All scenarios use CHANNELS = 2 and MESSAGE_WIDTH = 8.
- Reset and basic playback:
  - Stimulus: RST, load ch0 = 8'b1011_0010, ch1 = 8'hFF; start with rate = 3, length = 0, mode = loop.
  - Required: frame at t+1; out[0] sequence 0,1,0,0,1,1,0,1, each bit held 3 cycles; out[1] = 1 throughout; frame pulse every 24 cycles.
- One-shot:
  - Stimulus: length = 4, rate = 2, mode = 1.
  - Required: busy for exactly 8 cycles; done pulses once in the cycle busy falls; out = 0 afterwards; a start in the done cycle restarts with frame pulsed the next cycle.
- Mid-play load:
  - Stimulus: in loop mode, load ch0 = 8'h0F during frame 1.
  - Required: frame 1 is unchanged; frame 2 plays 8'h0F; load_channel = 3 has no effect.
- Stop and start collisions:
  - Stimulus: start and stop in the same cycle; stop on the final cycle of a one-shot frame.
  - Required: start+stop stays IDLE; stop on the final cycle gives no done and no frame, and busy = 0 next cycle.
- Edge rates and lengths:
  - Stimulus: rate = 0; length = 9; tick_rate changed mid-run.
  - Required: rate 0 behaves as 1; length 9 behaves as 8; the mid-run change is ignored until restart.
- Reset mid-operation:
  - Stimulus: RST asserted during RUN.
  - Required: next cycle, all outputs are 0; a following start plays all-zero patterns.
